// File: rtl/alarm_ctrl_if.sv
// UART byte-link bundle between the alarm core and the Bluetooth reader/writer.
// master = UART side (drives received bytes and writer-idle), slave = alarm core.
interface alarm_ctrl_if;
    logic       rx_arr;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_send;
    logic [7:0] tx_data;

    modport master (output rx_arr, rx_data, tx_ready, input tx_send, tx_data);
    modport slave  (input rx_arr, rx_data, tx_ready, output tx_send, tx_data);
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm core: threshold compare per channel, arm/exit-delay/alarm FSM, buzzer and status frames.
// Optional ALARM_BEEP_EN: intermittent alarm buzzer toggled on each tick.
module alarm_ctrl #(
    parameter int unsigned   N_CH      = 3,
    parameter int unsigned   W         = 16,
    parameter int unsigned   TRIP_CNT  = 3,
    parameter int unsigned   ARM_TICKS = 10,
    parameter logic [W-1:0]  THR_INIT  = {W{1'b1}}
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N_CH-1:0]   sample_vld,
    input  logic [N_CH*W-1:0] sample,
    input  logic              tick,
    alarm_ctrl_if.slave       uart,
    output logic              buzz_n,
    output logic [1:0]        state,
    output logic [N_CH-1:0]   trip
);
    localparam int unsigned NB    = W / 8;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CNT_W = $clog2(TRIP_CNT + 1);
    localparam int unsigned TK_W  = $clog2(ARM_TICKS + 1);

    typedef enum logic [1:0] {S_DISARMED = 2'd0, S_ARMING = 2'd1, S_ARMED = 2'd2, S_ALARM = 2'd3} st_e;
    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_GAP = 2'd2} tx_e;

    st_e              st_q, st_d;
    logic [TK_W-1:0]  tcnt_q, tcnt_d;
    logic [N_CH-1:0]  trip_d;
    logic             manual_q;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [W-1:0]     thr_q [N_CH];
    logic [N_CH-1:0]  hit, thr_clr;

    logic             loading_q;
    logic [IDX_W-1:0] lidx_q;
    logic [2:0]       lch_q;
    logic [W-1:0]     acc_q, acc_nx;
    logic             is_cmd, cmd_arm, cmd_dis, cmd_ld, cmd_stat, ld_last;
    logic             counting, alarm_term;

    tx_e              tx_q, tx_d;
    logic [1:0]       bidx_q, bidx_d;
    logic             pend_q, pend_d, send_d, req;
    logic [7:0]       data_d, byte_sel;

    // Command decode: while a threshold load is in progress every byte is data
    assign is_cmd   = uart.rx_arr & ~loading_q;
    assign cmd_arm  = is_cmd && (uart.rx_data == 8'hA5);
    assign cmd_dis  = is_cmd && (uart.rx_data == 8'h5A);
    assign cmd_stat = is_cmd && (uart.rx_data == 8'hE0);
    assign cmd_ld   = is_cmd && (uart.rx_data[7:3] == 5'b11000) && (32'(uart.rx_data[2:0]) < N_CH);
    assign ld_last  = uart.rx_arr && loading_q && (lidx_q == IDX_W'(NB - 1));
    assign acc_nx   = W'({acc_q, uart.rx_data});
    assign counting = (st_q == S_ARMED) || (st_q == S_ALARM);

    // Per-channel consecutive over-threshold counters
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            thr_clr[c] = ld_last && (lch_q == 3'(c));
            hit[c]     = 1'b0;
            cnt_d[c]   = cnt_q[c];
            if (!counting || cmd_dis || thr_clr[c]) begin
                cnt_d[c] = '0;
            end else if (sample_vld[c]) begin
                if (sample[c*W +: W] > thr_q[c]) begin
                    cnt_d[c] = (cnt_q[c] == CNT_W'(TRIP_CNT)) ? cnt_q[c] : cnt_q[c] + CNT_W'(1);
                    hit[c]   = (cnt_d[c] == CNT_W'(TRIP_CNT));
                end else begin
                    cnt_d[c] = '0;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            st_q   <= S_DISARMED;
            tcnt_q <= '0;
            trip   <= '0;
        end else begin
            st_q   <= st_d;
            tcnt_q <= tcnt_d;
            trip   <= trip_d;
        end
    end

    // Main FSM; disarm overrides everything else in the same cycle
    always_comb begin
        st_d   = st_q;
        tcnt_d = tcnt_q;
        trip_d = trip | hit;
        case (st_q)
            S_DISARMED: if (cmd_arm) begin
                st_d   = S_ARMING;
                tcnt_d = '0;
            end
            S_ARMING: if (tick) begin
                if (tcnt_q == TK_W'(ARM_TICKS - 1)) begin
                    st_d   = S_ARMED;
                    tcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_q + TK_W'(1);
                end
            end
            S_ARMED: if (|hit) st_d = S_ALARM;
            default: ;
        endcase
        if (cmd_dis) begin
            st_d   = S_DISARMED;
            tcnt_d = '0;
            trip_d = '0;
        end
    end

    assign state = st_q;

`ifdef ALARM_BEEP_EN
    logic beep_q;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)               beep_q <= 1'b1;
        else if (st_q != S_ALARM) beep_q <= 1'b1;
        else if (tick)            beep_q <= ~beep_q;
    end
    assign alarm_term = (st_q == S_ALARM) && beep_q;
`else
    assign alarm_term = (st_q == S_ALARM);
`endif

    // Manual flag, thresholds, load parser, counters, buzzer
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            manual_q  <= 1'b0;
            loading_q <= 1'b0;
            lidx_q    <= '0;
            lch_q     <= '0;
            acc_q     <= '0;
            buzz_n    <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
                thr_q[c] <= THR_INIT;
            end
        end else begin
            if (is_cmd && uart.rx_data == 8'h88) manual_q <= 1'b1;
            if (is_cmd && uart.rx_data == 8'h99) manual_q <= 1'b0;
            if (cmd_ld) begin
                loading_q <= 1'b1;
                lch_q     <= uart.rx_data[2:0];
                lidx_q    <= '0;
                acc_q     <= '0;
            end else if (uart.rx_arr && loading_q) begin
                acc_q  <= acc_nx;
                lidx_q <= lidx_q + IDX_W'(1);
                if (ld_last) loading_q <= 1'b0;
            end
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                if (thr_clr[c]) thr_q[c] <= acc_nx;
            end
            buzz_n <= ~(manual_q | alarm_term);
        end
    end

    // Status frame writer
    assign req = tick | cmd_stat;

    always_comb begin
        case (bidx_q)
            2'd0:    byte_sel = 8'h55;
            2'd1:    byte_sel = {4'hA, manual_q, 1'b0, st_q};
            default: byte_sel = 8'(trip);
        endcase
    end

    always_comb begin
        tx_d   = tx_q;
        bidx_d = bidx_q;
        pend_d = pend_q;
        send_d = 1'b0;
        data_d = uart.tx_data;
        case (tx_q)
            TX_IDLE: if (req || pend_q) begin
                tx_d   = TX_SEND;
                bidx_d = '0;
                pend_d = 1'b0;
            end
            TX_SEND: begin
                if (req) pend_d = 1'b1;
                if (uart.tx_ready) begin
                    send_d = 1'b1;
                    data_d = byte_sel;
                    tx_d   = TX_GAP;
                end
            end
            default: begin
                if (req) pend_d = 1'b1;
                if (bidx_q == 2'd2) begin
                    tx_d = TX_IDLE;
                end else begin
                    tx_d   = TX_SEND;
                    bidx_d = bidx_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_q         <= TX_IDLE;
            bidx_q       <= '0;
            pend_q       <= 1'b0;
            uart.tx_send <= 1'b0;
            uart.tx_data <= '0;
        end else begin
            tx_q         <= tx_d;
            bidx_q       <= bidx_d;
            pend_q       <= pend_d;
            uart.tx_send <= send_d;
            uart.tx_data <= data_d;
        end
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// Randomized scoreboard bench for alarm_ctrl: a rule-level model pushes per-cycle
// expectations, a monitor pops and compares on each cycle and on every tx_send.
module tb_alarm_ctrl;
    localparam int N_CH = 3;
    localparam int W = 16;
    localparam int TRIP_CNT = 3;
    localparam int ARM_TICKS = 10;
`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [N_CH-1:0]   sample_vld = '0;
    logic [N_CH*W-1:0] sample = '0;
    logic              tick = 1'b0;
    logic              buzz_n;
    logic [1:0]        state;
    logic [N_CH-1:0]   trip;

    alarm_ctrl_if u_if ();

    alarm_ctrl #(.N_CH(N_CH), .W(W), .TRIP_CNT(TRIP_CNT), .ARM_TICKS(ARM_TICKS)) dut (
        .Clock(Clock), .Reset(Reset), .sample_vld(sample_vld), .sample(sample), .tick(tick),
        .uart(u_if.slave), .buzz_n(buzz_n), .state(state), .trip(trip)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]      st;
        logic [N_CH-1:0] tr;
        logic            bz;
        logic [7:0]      sb;
        logic [7:0]      tb;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int frames = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state (values visible after the last clock edge)
    int           m_state, m_manual, m_ticks, m_beep, ld_left, ld_ch;
    logic [N_CH-1:0] m_trip;
    int           m_cnt [N_CH];
    logic [W-1:0] m_thr [N_CH];
    logic [W-1:0] ld_acc;

    task automatic model_reset();
        m_state = 0; m_manual = 0; m_ticks = 0; m_beep = 1; ld_left = 0; ld_ch = 0;
        m_trip = '0; ld_acc = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0;
            m_thr[c] = '1;
        end
    endtask

    task automatic model_step();
        int              o_state = m_state;
        int              o_manual = m_manual;
        int              o_beep = m_beep;
        logic [N_CH-1:0] o_trip = m_trip;
        logic [N_CH-1:0] hit = '0;
        bit              dis = 0, arm = 0, commit = 0;
        exp_t            e;
        if (u_if.rx_arr) begin
            if (ld_left > 0) begin
                ld_acc = W'({ld_acc, u_if.rx_data});
                ld_left--;
                if (ld_left == 0) commit = 1;
            end else begin
                case (u_if.rx_data)
                    8'h88: m_manual = 1;
                    8'h99: m_manual = 0;
                    8'hA5: arm = 1;
                    8'h5A: dis = 1;
                    default:
                        if (u_if.rx_data[7:3] == 5'b11000 && int'(u_if.rx_data[2:0]) < N_CH) begin
                            ld_left = W / 8;
                            ld_ch = int'(u_if.rx_data[2:0]);
                            ld_acc = '0;
                        end
                endcase
            end
        end
        if (o_state >= 2) begin
            for (int c = 0; c < N_CH; c++) begin
                if (commit && c == ld_ch) m_cnt[c] = 0;
                else if (sample_vld[c]) begin
                    if (sample[c*W +: W] > m_thr[c]) begin
                        if (m_cnt[c] < TRIP_CNT) m_cnt[c]++;
                        if (m_cnt[c] == TRIP_CNT) hit[c] = 1'b1;
                    end else m_cnt[c] = 0;
                end
            end
        end
        if (commit) m_thr[ld_ch] = ld_acc;
        if (dis) begin
            m_state = 0; m_trip = '0; m_ticks = 0;
            for (int c = 0; c < N_CH; c++) m_cnt[c] = 0;
        end else begin
            m_trip = o_trip | hit;
            if (o_state == 0 && arm) begin
                m_state = 1; m_ticks = 0;
            end else if (o_state == 1 && tick) begin
                m_ticks++;
                if (m_ticks == ARM_TICKS) m_state = 2;
            end else if (o_state == 2 && hit != 0) begin
                m_state = 3;
            end
        end
        if (o_state != 3) m_beep = 1;
        else if (tick) m_beep = (o_beep == 0) ? 1 : 0;
        e.st = 2'(m_state);
        e.tr = m_trip;
        e.bz = !((o_manual != 0) || (o_state == 3 && (!BEEP || o_beep != 0)));
        e.sb = {4'hA, 1'(o_manual), 1'b0, 2'(o_state)};
        e.tb = 8'(o_trip);
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge Clock);
        if (Reset) model_step();
    end

    // Monitor: per-cycle outputs plus each transmitted byte
    initial begin
        int   tx_pos = 0;
        logic prev_ready = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", longint'(state), longint'(e.st));
                chk("trip", longint'(trip), longint'(e.tr));
                chk("buzz_n", longint'(buzz_n), longint'(e.bz));
                if (u_if.tx_send) begin
                    chk("tx_gate", longint'(prev_ready), 1);
                    case (tx_pos)
                        0:       chk("tx_byte0", longint'(u_if.tx_data), 64'h55);
                        1:       chk("tx_byte1", longint'(u_if.tx_data), longint'(e.sb));
                        default: chk("tx_byte2", longint'(u_if.tx_data), longint'(e.tb));
                    endcase
                    tx_pos = (tx_pos + 1) % 3;
                    if (tx_pos == 0) frames++;
                end
            end
            prev_ready = u_if.tx_ready;
        end
    end

    // UART writer: busy for a few cycles after each byte
    initial begin
        int busy = 0;
        u_if.tx_ready = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            if (u_if.tx_send) busy = $urandom_range(1, 5);
            if (busy > 0) begin
                u_if.tx_ready = 1'b0;
                busy--;
            end else u_if.tx_ready = 1'b1;
        end
    end

    task automatic cyc(input bit arr, input logic [7:0] d, input bit tk,
                       input logic [N_CH-1:0] v, input logic [N_CH*W-1:0] s);
        u_if.rx_arr = arr; u_if.rx_data = d; tick = tk; sample_vld = v; sample = s;
        @(posedge Clock);
        #1;
        u_if.rx_arr = 1'b0; tick = 1'b0; sample_vld = '0;
    endtask

    task automatic rx(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, '0, '0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            idle(2);
            cyc(1'b0, 8'h00, 1'b1, '0, '0);
        end
        idle(2);
    endtask

    task automatic smp(input int c, input logic [W-1:0] val);
        logic [N_CH*W-1:0] sv = '0;
        logic [N_CH-1:0]   vv = '0;
        sv[c*W +: W] = val;
        vv[c] = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, vv, sv);
        idle(1);
    endtask

    initial begin
        int f0;
        u_if.rx_arr = 1'b0;
        u_if.rx_data = '0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_state", longint'(state), 0);
        chk("rst_trip", longint'(trip), 0);
        chk("rst_buzz_n", longint'(buzz_n), 1);
        chk("rst_tx_send", longint'(u_if.tx_send), 0);
        chk("rst_tx_data", longint'(u_if.tx_data), 0);
        Reset = 1'b1;

        rx(8'h88); idle(3); rx(8'h99); idle(3);

        // Arm coinciding with a tick: that tick is not part of the exit delay
        cyc(1'b1, 8'hA5, 1'b1, '0, '0);
        ticks(ARM_TICKS);

        rx(8'hC0); rx(8'h01); rx(8'h00);
        smp(0, 16'h0101); smp(0, 16'h0101); smp(0, 16'h0100);
        smp(0, 16'h0101); smp(0, 16'h0101); smp(0, 16'h0101);
        idle(3); rx(8'h5A); idle(3);

        // Disarm arriving together with the tripping sample
        rx(8'hA5); ticks(ARM_TICKS);
        smp(0, 16'h0101); smp(0, 16'h0101);
        cyc(1'b1, 8'h5A, 1'b0, 3'b001, 48'h0101);
        idle(3);

        // Three status requests during a frame yield exactly one extra frame
        idle(80);
        f0 = frames;
        cyc(1'b0, 8'h00, 1'b1, '0, '0);
        rx(8'hE0); rx(8'hE0); rx(8'hE0);
        idle(120);
        chk("frame_count", longint'(frames - f0), 2);

        rx(8'hC2); rx(8'h5A); rx(8'hA5); idle(2);
        rx(8'hC7); rx(8'hA5);
        ticks(ARM_TICKS);
        smp(2, 16'h5AA5); smp(2, 16'h5AA5); smp(2, 16'h5AA5);
        smp(2, 16'h5AA6); smp(2, 16'h5AA6); smp(2, 16'h5AA6);
        idle(3); rx(8'h5A); idle(3);

        repeat (4000) begin
            logic [7:0]        b;
            logic [N_CH*W-1:0] sv;
            logic [N_CH-1:0]   vv;
            int                r = $urandom_range(0, 31);
            if (r < 6)       b = 8'hA5;
            else if (r == 6) b = 8'h5A;
            else if (r == 7) b = 8'h88;
            else if (r == 8) b = 8'h99;
            else if (r == 9) b = 8'hE0;
            else if (r < 14) b = 8'hC0 + 8'($urandom_range(0, 7));
            else             b = 8'($urandom);
            vv = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++)
                sv[c*W +: W] = ($urandom_range(0, 1) == 1) ?
                               m_thr[c] + W'($urandom_range(0, 2)) - W'(1) : W'($urandom);
            cyc($urandom_range(0, 5) == 0, b, $urandom_range(0, 3) == 0, vv, sv);
        end
        idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
